// File: rtl/reg3_write_arbiter.sv
// Purpose : round-robin write arbiter between requesters A and B driving a bank
//           of NREG 3-bit enable registers through a one-hot enable and a shared data bus.
// Latency : request sampled at edge k, enable/data/ack registered for cycle k..k+1,
//           register captures on edge k+1.
// Backpressure: requesters hold REQ until their ACK pulse; at most one write per
//           two cycles, and requests are ignored during the WRITE cycle.
//
// Ports:
//   in_CLK, in_RST             clock, synchronous active-high reset
//   in_REQ_A/in_ADDR_A/in_D_A  requester A request, target index, data
//   in_REQ_B/in_ADDR_B/in_D_B  requester B request, target index, data
//   out_EN                     one-hot register enable (all zero when idle or out of range)
//   out_D                      shared write data (zero when idle)
//   out_ACK_A, out_ACK_B       one-cycle grant pulse, coincident with the write
//   out_BUSY                   high during the WRITE cycle
//   out_ERR                    one-cycle pulse when the granted index is >= NREG
//
// NREG must not exceed 2**AW.
module reg3_write_arbiter #(
  parameter int NREG = 4,
  parameter int AW   = 2,
  parameter int DW   = 3
) (
  input  logic            in_CLK,
  input  logic            in_RST,
  input  logic            in_REQ_A,
  input  logic [AW-1:0]   in_ADDR_A,
  input  logic [DW-1:0]   in_D_A,
  input  logic            in_REQ_B,
  input  logic [AW-1:0]   in_ADDR_B,
  input  logic [DW-1:0]   in_D_B,
  output logic [NREG-1:0] out_EN,
  output logic [DW-1:0]   out_D,
  output logic            out_ACK_A,
  output logic            out_ACK_B,
  output logic            out_BUSY,
  output logic            out_ERR
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  state_t state, state_nxt;

  // Priority pointer: 0 = A wins a tie, 1 = B wins a tie.
  logic ptr_b, ptr_b_nxt;

  // Next values for the output registers. The output registers double as the
  // holding stage: the winner's address is stored already decoded in out_EN
  // and its data in out_D, so later ADDR/D changes cannot disturb the write.
  logic [NREG-1:0] en_nxt;
  logic [DW-1:0]   d_nxt;
  logic            ack_a_nxt;
  logic            ack_b_nxt;
  logic            busy_nxt;
  logic            err_nxt;

  // Winner selection, valid only when at least one request is present.
  logic            win_b;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_d;
  logic [NREG-1:0] sel_onehot;

  always_comb begin
    win_b    = in_REQ_B && (!in_REQ_A || ptr_b);
    sel_addr = win_b ? in_ADDR_B : in_ADDR_A;
    sel_d    = win_b ? in_D_B    : in_D_A;
  end

  // Decode only the indices that exist; an out-of-range index leaves the
  // vector all zero, which is also how the error case is detected.
  always_comb begin
    sel_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      sel_onehot[i] = (sel_addr == AW'(i));
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_b_nxt = ptr_b;
    en_nxt    = '0;
    d_nxt     = '0;
    ack_a_nxt = 1'b0;
    ack_b_nxt = 1'b0;
    busy_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      S_IDLE: begin
        if (in_REQ_A || in_REQ_B) begin
          state_nxt = S_WRITE;
          // Hand priority to the loser; the pointer moves only on a grant.
          ptr_b_nxt = !win_b;
          en_nxt    = sel_onehot;
          d_nxt     = sel_d;
          ack_a_nxt = !win_b;
          ack_b_nxt = win_b;
          busy_nxt  = 1'b1;
          err_nxt   = ~|sel_onehot;
        end
      end
      S_WRITE: begin
        // The write lands on this edge; requests are not looked at here.
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state     <= S_IDLE;
      ptr_b     <= 1'b0;
      out_EN    <= '0;
      out_D     <= '0;
      out_ACK_A <= 1'b0;
      out_ACK_B <= 1'b0;
      out_BUSY  <= 1'b0;
      out_ERR   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr_b     <= ptr_b_nxt;
      out_EN    <= en_nxt;
      out_D     <= d_nxt;
      out_ACK_A <= ack_a_nxt;
      out_ACK_B <= ack_b_nxt;
      out_BUSY  <= busy_nxt;
      out_ERR   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_reg3_write_arbiter.sv
// Bench for reg3_write_arbiter: two instances (NREG=4 and NREG=3, AW=2) share
// the same stimulus; a transaction-level model predicts the outputs and the
// contents of a register bank attached to each instance.
module tb_reg3_write_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [1:0] addr_a, addr_b;
  logic [2:0] d_a, d_b;

  logic [3:0] en4;
  logic [2:0] en3;
  logic [2:0] dq4, dq3;
  logic       ack_a4, ack_b4, busy4, err4;
  logic       ack_a3, ack_b3, busy3, err3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reg3_write_arbiter #(.NREG(4), .AW(2), .DW(3)) dut4 (
    .in_CLK(clk), .in_RST(rst),
    .in_REQ_A(req_a), .in_ADDR_A(addr_a), .in_D_A(d_a),
    .in_REQ_B(req_b), .in_ADDR_B(addr_b), .in_D_B(d_b),
    .out_EN(en4), .out_D(dq4), .out_ACK_A(ack_a4), .out_ACK_B(ack_b4),
    .out_BUSY(busy4), .out_ERR(err4)
  );

  reg3_write_arbiter #(.NREG(3), .AW(2), .DW(3)) dut3 (
    .in_CLK(clk), .in_RST(rst),
    .in_REQ_A(req_a), .in_ADDR_A(addr_a), .in_D_A(d_a),
    .in_REQ_B(req_b), .in_ADDR_B(addr_b), .in_D_B(d_b),
    .out_EN(en3), .out_D(dq3), .out_ACK_A(ack_a3), .out_ACK_B(ack_b3),
    .out_BUSY(busy3), .out_ERR(err3)
  );

  // Register banks fed by the DUT outputs, as the real bank would be.
  logic [2:0] bank4 [4];
  logic [2:0] bank3 [3];

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (en4[i]) bank4[i] <= dq4;
    for (int i = 0; i < 3; i++) if (en3[i]) bank3[i] <= dq3;
  end

  // Reference model, one slot per instance. A pending write is a transaction
  // that is shown on the bus for one cycle and committed on the next edge.
  int nreg_of [2] = '{4, 3};
  bit m_pending [2];
  bit m_prio_b  [2];
  int m_addr    [2];
  int exp_en    [2];
  int exp_d     [2];
  int exp_acka  [2];
  int exp_ackb  [2];
  int exp_err   [2];
  int mbank     [2][4];

  task automatic clear_expect(input int k);
    m_pending[k] = 0;
    exp_en[k]    = 0;
    exp_d[k]     = 0;
    exp_acka[k]  = 0;
    exp_ackb[k]  = 0;
    exp_err[k]   = 0;
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      bit was_pending;
      was_pending = m_pending[k];
      // The bus content of the finished cycle lands in the bank on this edge,
      // even if reset is asserted on the same edge.
      if (was_pending && exp_err[k] == 0) mbank[k][m_addr[k]] = exp_d[k];
      if (rst) begin
        clear_expect(k);
        m_prio_b[k] = 0;
      end else if (was_pending || !(req_a || req_b)) begin
        clear_expect(k);
      end else begin
        bit b_wins;
        b_wins       = req_b && (!req_a || m_prio_b[k]);
        m_addr[k]    = b_wins ? int'(addr_b) : int'(addr_a);
        exp_d[k]     = b_wins ? int'(d_b) : int'(d_a);
        m_prio_b[k]  = !b_wins;
        m_pending[k] = 1;
        exp_acka[k]  = b_wins ? 0 : 1;
        exp_ackb[k]  = b_wins ? 1 : 0;
        exp_err[k]   = (m_addr[k] >= nreg_of[k]) ? 1 : 0;
        exp_en[k]    = exp_err[k] ? 0 : (1 << m_addr[k]);
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("en4",   32'(en4),    32'(exp_en[0]));
    check("d4",    32'(dq4),    32'(exp_d[0]));
    check("acka4", 32'(ack_a4), 32'(exp_acka[0]));
    check("ackb4", 32'(ack_b4), 32'(exp_ackb[0]));
    check("busy4", 32'(busy4),  32'(m_pending[0]));
    check("err4",  32'(err4),   32'(exp_err[0]));
    check("en3",   32'(en3),    32'(exp_en[1]));
    check("d3",    32'(dq3),    32'(exp_d[1]));
    check("acka3", 32'(ack_a3), 32'(exp_acka[1]));
    check("ackb3", 32'(ack_b3), 32'(exp_ackb[1]));
    check("busy3", 32'(busy3),  32'(m_pending[1]));
    check("err3",  32'(err3),   32'(exp_err[1]));
    for (int i = 0; i < 4; i++) check("bank4", 32'(bank4[i]), 32'(mbank[0][i]));
    for (int i = 0; i < 3; i++) check("bank3", 32'(bank3[i]), 32'(mbank[1][i]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      bank4[i] = '0;
      mbank[0][i] = 0;
      mbank[1][i] = 0;
    end
    for (int i = 0; i < 3; i++) bank3[i] = '0;
    for (int k = 0; k < 2; k++) begin
      clear_expect(k);
      m_prio_b[k] = 0;
      m_addr[k]   = 0;
    end
    rst = 1'b1; req_a = 1'b1; req_b = 1'b0;
    addr_a = 2'd0; d_a = 3'd1; addr_b = 2'd0; d_b = 3'd0;

    // Reset held two cycles with A requesting: outputs stay zero.
    tick(); tick();
    // Release: first grant goes to A on the next edge.
    rst = 1'b0;
    tick();
    check("first_grant_a", 32'(ack_a4), 32'd1);
    req_a = 1'b0;
    tick();

    // Single A write: reg2 <= 101.
    req_a = 1'b1; addr_a = 2'd2; d_a = 3'b101;
    tick();
    check("single_en", 32'(en4), 32'h4);
    req_a = 1'b0;
    tick();
    check("single_bank2", 32'(bank4[2]), 32'h5);

    // Contention held continuously: grants alternate, one per two cycles.
    req_a = 1'b1; addr_a = 2'd0; d_a = 3'b001;
    req_b = 1'b1; addr_b = 2'd3; d_b = 3'b110;
    repeat (8) tick();
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // Reset asserted on the edge that would enter WRITE: no enable, no ACK.
    req_a = 1'b1; addr_a = 2'd1; d_a = 3'b011;
    req_b = 1'b1; addr_b = 2'd2; d_b = 3'b100;
    rst = 1'b1;
    tick();
    check("rst_mid_en", 32'(en4), 32'h0);
    rst = 1'b0;
    tick();   // pointer back at A: A wins the tie
    check("rst_ptr_a", 32'(ack_a4), 32'd1);
    req_a = 1'b0; req_b = 1'b0;
    tick();

    // Out-of-range index for the NREG=3 instance.
    req_b = 1'b1; addr_b = 2'd3; d_b = 3'b111;
    tick();
    check("oor_err3", 32'(err3), 32'd1);
    req_b = 1'b0;
    tick(); tick();

    // Data change right after the sampling edge does not reach the bus.
    req_a = 1'b1; addr_a = 2'd1; d_a = 3'b010;
    tick();
    d_a = 3'b111; req_a = 1'b0;
    tick();
    check("stable_bank1", 32'(bank4[1]), 32'h2);
    tick();

    // Randomized phase.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 31) == 0);
      req_a  = 1'($urandom_range(0, 1));
      req_b  = 1'($urandom_range(0, 1));
      addr_a = 2'($urandom_range(0, 3));
      addr_b = 2'($urandom_range(0, 3));
      d_a    = 3'($urandom_range(0, 7));
      d_b    = 3'($urandom_range(0, 7));
      tick();
      check("onehot4", 32'($countones(en4) <= 1), 32'd1);
      check("ackx4",   32'(ack_a4 & ack_b4),      32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
